// File: rtl/key_entry_fsm.sv
// key_entry_fsm
//   Debounces the keypad scanner's key-present level and turns each physical
//   press into one key event. Digit keys are shifted into a BCD operand.
//   Operator keys emit a one-cycle event that carries a snapshot of the
//   operand. The clear key resets the operand.
//
// Ports
//   CLK          system clock, rising edge
//   RESET        synchronous active-high reset
//   BCDKey[3:0]  scanner key code: 0-9 digit, 13 clear, 10/11/12/14/15 operator
//   KeyRead      scanner key-present level, already in the CLK domain
//   operand      BCD operand being typed, most recent digit in [3:0]
//   digit_count  number of significant digits held
//   overflow     sticky: a digit was dropped because the operand was full
//   op_valid     one-cycle pulse on an accepted operator key
//   op_code      code of the last accepted operator
//   op_operand   operand captured at the last accepted operator
//   clr_pulse    one-cycle pulse on an accepted clear key
module key_entry_fsm #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NDIGITS         = 4
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [3:0]                       BCDKey,
  input  logic                             KeyRead,
  output logic [4*NDIGITS-1:0]             operand,
  output logic [$clog2(NDIGITS+1)-1:0]     digit_count,
  output logic                             overflow,
  output logic                             op_valid,
  output logic [3:0]                       op_code,
  output logic [4*NDIGITS-1:0]             op_operand,
  output logic                             clr_pulse
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DCW = $clog2(NDIGITS + 1);
  localparam int OW  = 4 * NDIGITS;

  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [DCW-1:0] DIG_FULL = DCW'(NDIGITS);
  localparam logic [3:0]     KEY_CLR  = 4'd13;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [3:0]      cand_reg, cand_next;
  logic            accept;
  logic [3:0]      accept_key;

  logic [OW-1:0]   operand_reg, operand_next, operand_shifted;
  logic [DCW-1:0]  digit_count_reg, digit_count_next;
  logic            overflow_reg, overflow_next;
  logic            op_valid_reg, op_valid_next;
  logic [3:0]      op_code_reg, op_code_next;
  logic [OW-1:0]   op_operand_reg, op_operand_next;
  logic            clr_pulse_reg, clr_pulse_next;

  // Sample counter saturates at the debounce threshold.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

  // ---------------- debounce FSM ----------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    accept     = 1'b0;
    accept_key = cand_reg;
    case (state_reg)
      IDLE: begin
        if (KeyRead) begin
          cand_next = BCDKey;
          cnt_next  = CNT_ONE;
          if (CNT_ONE == CNT_MAX) begin
            // A one-sample debounce accepts on the first sample.
            accept     = 1'b1;
            accept_key = BCDKey;
            state_next = HELD;
          end else begin
            state_next = PRESS_CHK;
          end
        end
      end
      PRESS_CHK: begin
        if (!KeyRead) begin
          state_next = IDLE;
        end else if (BCDKey != cand_reg) begin
          // The code changed while bouncing, so restart with the new candidate.
          cand_next = BCDKey;
          cnt_next  = CNT_ONE;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            accept     = 1'b1;
            state_next = HELD;
          end
        end
      end
      HELD: begin
        // Code changes are ignored here so that one press gives one event.
        if (!KeyRead) begin
          cnt_next   = CNT_ONE;
          state_next = (CNT_ONE == CNT_MAX) ? IDLE : REL_CHK;
        end
      end
      REL_CHK: begin
        if (KeyRead) begin
          state_next = HELD;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand with the accepted key shifted in as the least significant digit.
  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_shift
      if (gi == 0) begin : g_lsd
        assign operand_shifted[3:0] = accept_key;
      end else begin : g_upper
        assign operand_shifted[4*gi +: 4] = operand_reg[4*(gi-1) +: 4];
      end
    end
  endgenerate

  // ---------------- key action ----------------
  always_comb begin
    operand_next     = operand_reg;
    digit_count_next = digit_count_reg;
    overflow_next    = overflow_reg;
    op_valid_next    = 1'b0;
    op_code_next     = op_code_reg;
    op_operand_next  = op_operand_reg;
    clr_pulse_next   = 1'b0;
    if (accept) begin
      if (accept_key < 4'd10) begin
        if (accept_key == 4'd0 && digit_count_reg == '0) begin
          // Leading zeros are not counted.
        end else if (digit_count_reg == DIG_FULL) begin
          overflow_next = 1'b1;
        end else begin
          operand_next     = operand_shifted;
          digit_count_next = digit_count_reg + DCW'(1);
        end
      end else if (accept_key == KEY_CLR) begin
        operand_next     = '0;
        digit_count_next = '0;
        overflow_next    = 1'b0;
        clr_pulse_next   = 1'b1;
      end else begin
        op_operand_next  = operand_reg;
        op_code_next     = accept_key;
        op_valid_next    = 1'b1;
        operand_next     = '0;
        digit_count_next = '0;
        overflow_next    = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      cand_reg        <= '0;
      operand_reg     <= '0;
      digit_count_reg <= '0;
      overflow_reg    <= 1'b0;
      op_valid_reg    <= 1'b0;
      op_code_reg     <= '0;
      op_operand_reg  <= '0;
      clr_pulse_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      cand_reg        <= cand_next;
      operand_reg     <= operand_next;
      digit_count_reg <= digit_count_next;
      overflow_reg    <= overflow_next;
      op_valid_reg    <= op_valid_next;
      op_code_reg     <= op_code_next;
      op_operand_reg  <= op_operand_next;
      clr_pulse_reg   <= clr_pulse_next;
    end
  end

  assign operand     = operand_reg;
  assign digit_count = digit_count_reg;
  assign overflow    = overflow_reg;
  assign op_valid    = op_valid_reg;
  assign op_code     = op_code_reg;
  assign op_operand  = op_operand_reg;
  assign clr_pulse   = clr_pulse_reg;

endmodule

// File: tb/tb_key_entry_fsm.sv
// Testbench for key_entry_fsm with a four-sample debounce and four digits.
// Each cycle the outputs are compared against a model. The model keeps the
// last DC samples and a held flag, and it stores the operand as a decimal
// value. Table steps and hand sequences also check fixed expected values.
module tb_key_entry_fsm;
  localparam int DC = 4;
  localparam int ND = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  BCDKey = 4'd0;
  logic        KeyRead = 1'b0;
  logic [15:0] operand;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [15:0] op_operand;
  logic        clr_pulse;

  always #5 CLK = ~CLK;

  key_entry_fsm #(.DEBOUNCE_CYCLES(DC), .NDIGITS(ND)) dut (
    .CLK(CLK), .RESET(RESET), .BCDKey(BCDKey), .KeyRead(KeyRead),
    .operand(operand), .digit_count(digit_count), .overflow(overflow),
    .op_valid(op_valid), .op_code(op_code), .op_operand(op_operand),
    .clr_pulse(clr_pulse)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          held;
  bit          h_kr[$];
  logic [3:0]  h_key[$];
  int          m_val, m_cnt;
  bit          m_ovf, m_opv, m_clr;
  logic [3:0]  m_opcode;
  logic [15:0] m_opop;
  int          n_op, n_clr;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_key(input logic [3:0] k);
    if (k < 10) begin
      if (k == 0 && m_cnt == 0) begin
      end else if (m_cnt == ND) begin
        m_ovf = 1;
      end else begin
        m_val = m_val * 10 + int'(k);
        m_cnt++;
      end
    end else if (k == 13) begin
      m_val = 0; m_cnt = 0; m_ovf = 0; m_clr = 1;
    end else begin
      m_opop = to_bcd(m_val); m_opcode = k; m_opv = 1;
      m_val = 0; m_cnt = 0; m_ovf = 0;
    end
  endtask

  task automatic model_edge(input bit rst, input bit kr, input logic [3:0] key);
    bit all_hi, all_lo, same;
    m_opv = 0; m_clr = 0;
    if (rst) begin
      h_kr.delete(); h_key.delete(); held = 0;
      m_val = 0; m_cnt = 0; m_ovf = 0; m_opcode = 0; m_opop = 0;
      return;
    end
    h_kr.push_back(kr);
    h_key.push_back(key);
    if (h_kr.size() > DC) begin
      void'(h_kr.pop_front());
      void'(h_key.pop_front());
    end
    if (h_kr.size() == DC) begin
      all_hi = 1; all_lo = 1; same = 1;
      for (int i = 0; i < DC; i++) begin
        if (h_kr[i]) all_lo = 0; else all_hi = 0;
        if (h_key[i] != h_key[DC-1]) same = 0;
      end
      if (!held && all_hi && same) begin
        held = 1;
        model_key(h_key[DC-1]);
      end else if (held && all_lo) begin
        held = 0;
      end
    end
  endtask

  // One clock: drive, let the edge pass, then compare at the falling edge.
  task automatic tick(input bit rst, input bit kr, input logic [3:0] key);
    RESET = rst; KeyRead = kr; BCDKey = key;
    @(posedge CLK);
    model_edge(rst, kr, key);
    @(negedge CLK);
    chk("operand", 32'(operand), 32'(to_bcd(m_val)));
    chk("digit_count", 32'(digit_count), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("op_valid", 32'(op_valid), 32'(m_opv));
    chk("op_code", 32'(op_code), 32'(m_opcode));
    chk("op_operand", 32'(op_operand), 32'(m_opop));
    chk("clr_pulse", 32'(clr_pulse), 32'(m_clr));
    if (op_valid) n_op++;
    if (clr_pulse) n_clr++;
  endtask

  task automatic press(input logic [3:0] key, input int hold);
    for (int i = 0; i < hold; i++) tick(0, 1, key);
    for (int i = 0; i < 6; i++) tick(0, 0, key);
  endtask

  typedef struct {
    logic [3:0]  key;
    int          hold;
    logic [15:0] e_operand;
    int          e_cnt;
    bit          e_ovf;
    logic [3:0]  e_opcode;
    logic [15:0] e_opop;
    int          e_nop;
    int          e_nclr;
  } step_t;

  step_t tbl[15];

  initial begin
    tbl[0]  = '{4'd7,  10, 16'h0007, 1, 0, 4'd0,  16'h0000, 0, 0};
    tbl[1]  = '{4'd13,  5, 16'h0000, 0, 0, 4'd0,  16'h0000, 0, 1};
    tbl[2]  = '{4'd1,   5, 16'h0001, 1, 0, 4'd0,  16'h0000, 0, 0};
    tbl[3]  = '{4'd2,   6, 16'h0012, 2, 0, 4'd0,  16'h0000, 0, 0};
    tbl[4]  = '{4'd3,   4, 16'h0123, 3, 0, 4'd0,  16'h0000, 0, 0};
    tbl[5]  = '{4'd4,   7, 16'h1234, 4, 0, 4'd0,  16'h0000, 0, 0};
    tbl[6]  = '{4'd5,   5, 16'h1234, 4, 1, 4'd0,  16'h0000, 0, 0};
    tbl[7]  = '{4'd10,  5, 16'h0000, 0, 0, 4'd10, 16'h1234, 1, 0};
    tbl[8]  = '{4'd0,   5, 16'h0000, 0, 0, 4'd10, 16'h1234, 0, 0};
    tbl[9]  = '{4'd0,   4, 16'h0000, 0, 0, 4'd10, 16'h1234, 0, 0};
    tbl[10] = '{4'd9,   5, 16'h0009, 1, 0, 4'd10, 16'h1234, 0, 0};
    tbl[11] = '{4'd4,   5, 16'h0094, 2, 0, 4'd10, 16'h1234, 0, 0};
    tbl[12] = '{4'd13,  5, 16'h0000, 0, 0, 4'd10, 16'h1234, 0, 1};
    tbl[13] = '{4'd15,  4, 16'h0000, 0, 0, 4'd15, 16'h0000, 1, 0};
    tbl[14] = '{4'd8,   8, 16'h0008, 1, 0, 4'd15, 16'h0000, 0, 0};

    // Reset state.
    tick(1, 0, 4'd0);
    tick(1, 0, 4'd0);
    chk("reset_operand", 32'(operand), 32'h0);
    chk("reset_count", 32'(digit_count), 32'h0);
    chk("reset_flags", 32'({overflow, op_valid, clr_pulse}), 32'h0);
    chk("reset_op", 32'({op_code, op_operand}), 32'h0);

    // A short glitch (3 high, 1 low, 3 high) must not be accepted.
    n_op = 0; n_clr = 0;
    for (int i = 0; i < 3; i++) tick(0, 1, 4'd5);
    tick(0, 0, 4'd5);
    for (int i = 0; i < 3; i++) tick(0, 1, 4'd5);
    for (int i = 0; i < 6; i++) tick(0, 0, 4'd5);
    chk("glitch_operand", 32'(operand), 32'h0);
    chk("glitch_count", 32'(digit_count), 32'h0);

    // Table of complete presses.
    for (int s = 0; s < 15; s++) begin
      n_op = 0; n_clr = 0;
      press(tbl[s].key, tbl[s].hold);
      chk($sformatf("tbl%0d_operand", s), 32'(operand), 32'(tbl[s].e_operand));
      chk($sformatf("tbl%0d_count", s), 32'(digit_count), 32'(tbl[s].e_cnt));
      chk($sformatf("tbl%0d_ovf", s), 32'(overflow), 32'(tbl[s].e_ovf));
      chk($sformatf("tbl%0d_opcode", s), 32'(op_code), 32'(tbl[s].e_opcode));
      chk($sformatf("tbl%0d_opop", s), 32'(op_operand), 32'(tbl[s].e_opop));
      chk($sformatf("tbl%0d_nop", s), 32'(n_op), 32'(tbl[s].e_nop));
      chk($sformatf("tbl%0d_nclr", s), 32'(n_clr), 32'(tbl[s].e_nclr));
    end

    // The code changes 3->6 during the press check. The 6 is accepted on the
    // fourth edge after the change. An 8 during HELD and a release glitch
    // must not add events.
    press(4'd13, 5);
    n_op = 0; n_clr = 0;
    tick(0, 1, 4'd3);
    tick(0, 1, 4'd3);
    for (int i = 0; i < 3; i++) tick(0, 1, 4'd6);
    chk("chg_before", 32'(operand), 32'h0);
    tick(0, 1, 4'd6);
    chk("chg_accept", 32'(operand), 32'h0006);
    for (int i = 0; i < 5; i++) tick(0, 1, 4'd8);
    tick(0, 0, 4'd8);
    tick(0, 0, 4'd8);
    tick(0, 1, 4'd8);
    tick(0, 1, 4'd8);
    for (int i = 0; i < 6; i++) tick(0, 0, 4'd8);
    chk("held_operand", 32'(operand), 32'h0006);
    chk("held_count", 32'(digit_count), 32'h1);

    // A reset during PRESS_CHK clears everything, and debounce then restarts.
    tick(0, 1, 4'd4);
    tick(0, 1, 4'd4);
    tick(1, 1, 4'd4);
    chk("midrst_operand", 32'(operand), 32'h0);
    chk("midrst_count", 32'(digit_count), 32'h0);
    chk("midrst_op", 32'({op_code, op_operand}), 32'h0);
    for (int i = 0; i < 3; i++) tick(0, 1, 4'd4);
    chk("midrst_wait", 32'(operand), 32'h0);
    tick(0, 1, 4'd4);
    chk("midrst_restart", 32'(operand), 32'h0004);
    for (int i = 0; i < 6; i++) tick(0, 0, 4'd4);

    // Random segments checked against the model every cycle.
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      bit kr;
      logic [3:0] key;
      len = $urandom_range(1, 9);
      kr  = 1'($urandom_range(0, 1));
      key = 4'($urandom_range(0, 15));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) key = 4'($urandom_range(0, 15));
        tick(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, kr, key);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
